iq_reader: RTL and testbench

- Consumer end of the instruction queue. Pops instructions from the queue and absorbs the queue's one-cycle registered read latency in a small skid buffer.
- Presents the two oldest instructions, each with a sequence tag, to dual-issue decode under a valid/ready handshake.
- Sits between the instruction queue and the decode/dispatch stage of the superscalar pipeline.

---
 rtl/iq_reader_pkg.sv | 13 +
 rtl/iq_skid_buf.sv | 76 +++++++
 rtl/iq_reader.sv | 81 ++++++++
 tb/tb_iq_reader.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/iq_reader_pkg.sv
// rtl/iq_reader_pkg.sv - shared widths and helpers for the instruction-queue reader
package iq_reader_pkg;

  localparam int IQ_IWIDTH = 32;
  localparam int IQ_DEPTH  = 4;
  localparam int IQ_SEQW   = 6;

  // Number of slots decode takes this cycle: 0, 1 or 2.
  function automatic logic [1:0] pop_amount(input logic ready, input logic v0, input logic v1);
    return ready ? ({1'b0, v0} + {1'b0, v1}) : 2'd0;
  endfunction

endpackage

// File: rtl/iq_skid_buf.sv
// rtl/iq_skid_buf.sv - circular buffer with one write port and a two-entry read window
module iq_skid_buf
  import iq_reader_pkg::*;
#(
  parameter int IWIDTH = IQ_IWIDTH,
  parameter int SEQW   = IQ_SEQW,
  parameter int DEPTH  = IQ_DEPTH,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush_i,
  input  logic              wr_en_i,
  input  logic [IWIDTH-1:0] wr_instr_i,
  input  logic [SEQW-1:0]   wr_seq_i,
  input  logic [1:0]        pop_i,
  output logic              valid0_o,
  output logic              valid1_o,
  output logic [IWIDTH-1:0] instr0_o,
  output logic [IWIDTH-1:0] instr1_o,
  output logic [SEQW-1:0]   seq0_o,
  output logic [SEQW-1:0]   seq1_o,
  output logic [CW-1:0]     count_o
);

  logic [IWIDTH-1:0] instr_mem_q [DEPTH];
  logic [SEQW-1:0]   seq_mem_q   [DEPTH];
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d, rd_ptr1;
  logic [CW-1:0]     count_q, count_d;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      rd_ptr_d = rd_ptr_q + PW'(pop_i);
      wr_ptr_d = wr_ptr_q + PW'(wr_en_i);
      count_d  = count_q + CW'(wr_en_i) - CW'(pop_i);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: occupancy alone decides what is visible.
  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      instr_mem_q[wr_ptr_q] <= wr_instr_i;
      seq_mem_q[wr_ptr_q]   <= wr_seq_i;
    end
  end

  assign rd_ptr1  = rd_ptr_q + PW'(1);
  assign valid0_o = (count_q != '0);
  assign valid1_o = (count_q >= CW'(2));
  assign instr0_o = valid0_o ? instr_mem_q[rd_ptr_q] : '0;
  assign instr1_o = valid1_o ? instr_mem_q[rd_ptr1]  : '0;
  assign seq0_o   = valid0_o ? seq_mem_q[rd_ptr_q]   : '0;
  assign seq1_o   = valid1_o ? seq_mem_q[rd_ptr1]    : '0;
  assign count_o  = count_q;

endmodule

// File: rtl/iq_reader.sv
// rtl/iq_reader.sv - pops the instruction queue and presents two tagged slots to decode
module iq_reader
  import iq_reader_pkg::*;
#(
  parameter int IWIDTH = IQ_IWIDTH,
  parameter int DEPTH  = IQ_DEPTH,
  parameter int SEQW   = IQ_SEQW,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic              r_clk,
  input  logic              r_rst,
  input  logic              r_i_iq_empty,
  output logic              r_o_iq_re,
  input  logic [IWIDTH-1:0] r_i_iq_instr,
  input  logic              r_i_flush,
  input  logic              r_i_ready,
  output logic              r_o_valid0,
  output logic              r_o_valid1,
  output logic [IWIDTH-1:0] r_o_instr0,
  output logic [IWIDTH-1:0] r_o_instr1,
  output logic [SEQW-1:0]   r_o_seq0,
  output logic [SEQW-1:0]   r_o_seq1,
  output logic [CW-1:0]     r_o_count
);

  logic            inflight_q, inflight_d;
  logic [SEQW-1:0] seq_q, seq_d;
  logic [CW:0]     used;
  logic            credit_ok;
  logic            capture;
  logic [1:0]      pop;

  // Credit counts the word still in flight so a full buffer never overflows;
  // a pop in this cycle deliberately does not count.
  assign used      = {1'b0, r_o_count} + (CW + 1)'(inflight_q);
  assign credit_ok = (used < (CW + 1)'(DEPTH));
  assign r_o_iq_re = !r_i_iq_empty && !r_i_flush && !r_rst && credit_ok;
  assign capture   = inflight_q && !r_i_flush;
  assign pop       = pop_amount(r_i_ready, r_o_valid0, r_o_valid1);

  always_comb begin
    inflight_d = r_o_iq_re;
    seq_d      = seq_q;
    if (capture) begin
      seq_d = seq_q + SEQW'(1);
    end
  end

  // The tag counter survives flush so tags stay unique across it.
  always_ff @(posedge r_clk) begin
    if (r_rst) begin
      inflight_q <= 1'b0;
      seq_q      <= '0;
    end else begin
      inflight_q <= inflight_d;
      seq_q      <= seq_d;
    end
  end

  iq_skid_buf #(
    .IWIDTH (IWIDTH),
    .SEQW   (SEQW),
    .DEPTH  (DEPTH)
  ) u_buf (
    .clk_i      (r_clk),
    .rst_i      (r_rst),
    .flush_i    (r_i_flush),
    .wr_en_i    (capture),
    .wr_instr_i (r_i_iq_instr),
    .wr_seq_i   (seq_q),
    .pop_i      (pop),
    .valid0_o   (r_o_valid0),
    .valid1_o   (r_o_valid1),
    .instr0_o   (r_o_instr0),
    .instr1_o   (r_o_instr1),
    .seq0_o     (r_o_seq0),
    .seq1_o     (r_o_seq1),
    .count_o    (r_o_count)
  );

endmodule

// File: tb/tb_iq_reader.sv
// tb/tb_iq_reader.sv - scoreboard bench for iq_reader with a registered-read queue model
module tb_iq_reader;

  localparam int IW = 32;
  localparam int SW = 6;
  localparam int CW = 3;

  logic          r_clk = 1'b0;
  logic          r_rst, r_i_iq_empty, r_o_iq_re, r_i_flush, r_i_ready;
  logic [IW-1:0] r_i_iq_instr = '0;
  logic          r_o_valid0, r_o_valid1;
  logic [IW-1:0] r_o_instr0, r_o_instr1;
  logic [SW-1:0] r_o_seq0, r_o_seq1;
  logic [CW-1:0] r_o_count;

  always #5 r_clk = ~r_clk;

  iq_reader dut (
    .r_clk        (r_clk),
    .r_rst        (r_rst),
    .r_i_iq_empty (r_i_iq_empty),
    .r_o_iq_re    (r_o_iq_re),
    .r_i_iq_instr (r_i_iq_instr),
    .r_i_flush    (r_i_flush),
    .r_i_ready    (r_i_ready),
    .r_o_valid0   (r_o_valid0),
    .r_o_valid1   (r_o_valid1),
    .r_o_instr0   (r_o_instr0),
    .r_o_instr1   (r_o_instr1),
    .r_o_seq0     (r_o_seq0),
    .r_o_seq1     (r_o_seq1),
    .r_o_count    (r_o_count)
  );

  typedef struct packed {
    logic [IW-1:0] instr;
    logic [SW-1:0] seq;
  } exp_t;

  exp_t          sb[$];
  logic [IW-1:0] qmem [0:255];
  int            wr_idx = 0;
  int            rd_idx = 0;
  int            re_cnt = 0;
  int            max_cnt = 0;
  int            n_checks = 0;
  int            n_errors = 0;

  // Upstream queue: one-cycle registered read.
  assign r_i_iq_empty = (rd_idx == wr_idx);
  always @(posedge r_clk) begin
    if (r_o_iq_re) begin
      r_i_iq_instr <= qmem[rd_idx[7:0]];
      rd_idx       <= rd_idx + 1;
      re_cnt       <= re_cnt + 1;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_slot(input string name, input logic [IW-1:0] instr, input logic [SW-1:0] seq);
    exp_t e;
    if (sb.size() == 0) begin
      chk({name, "_unexpected"}, {26'd0, seq, instr}, 64'd0);
    end else begin
      e = sb.pop_front();
      chk({name, "_instr"}, 64'(instr), 64'(e.instr));
      chk({name, "_seq"}, 64'(seq), 64'(e.seq));
    end
  endtask

  // Monitor: mid-cycle, every accepted slot must match the scoreboard head.
  always @(negedge r_clk) begin
    if (!r_rst) begin
      if (int'(r_o_count) > max_cnt) max_cnt = int'(r_o_count);
      if (r_o_valid1) chk("valid1_implies_valid0", 64'(r_o_valid0), 64'd1);
      if (r_i_ready && r_o_valid0) check_slot("slot0", r_o_instr0, r_o_seq0);
      if (r_i_ready && r_o_valid1) check_slot("slot1", r_o_instr1, r_o_seq1);
    end
  end

  task automatic tick();
    @(posedge r_clk);
    #1;
  endtask

  task automatic push(input logic [IW-1:0] instr, input logic [SW-1:0] seq, input bit expect_out);
    exp_t e;
    qmem[wr_idx[7:0]] = instr;
    wr_idx++;
    if (expect_out) begin
      e.instr = instr;
      e.seq   = seq;
      sb.push_back(e);
    end
  endtask

  task automatic wait_drain(input string name, input int budget);
    bit done = 0;
    for (int c = 0; c < budget; c++) begin
      if (sb.size() == 0 && r_o_count == '0 && rd_idx == wr_idx) begin
        done = 1;
        break;
      end
      tick();
    end
    chk({name, "_drained"}, 64'(done), 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int r0;
    bit done;
    r_rst = 1'b1; r_i_flush = 1'b0; r_i_ready = 1'b0;
    tick(); tick();
    chk("rst_count", 64'(r_o_count), 64'd0);
    chk("rst_valid0", 64'(r_o_valid0), 64'd0);
    chk("rst_valid1", 64'(r_o_valid1), 64'd0);
    chk("rst_re", 64'(r_o_iq_re), 64'd0);
    chk("rst_instr0", 64'(r_o_instr0), 64'd0);
    r_rst = 1'b0;

    // Streaming: credit limits reads to DEPTH while decode stalls.
    r0 = re_cnt;
    for (int i = 0; i < 8; i++) push(IW'(32'h10 + i), SW'(i), 1);
    repeat (10) tick();
    chk("stream_reads", 64'(re_cnt - r0), 64'd4);
    chk("stream_count", 64'(r_o_count), 64'd4);
    chk("stream_valid1", 64'(r_o_valid1), 64'd1);
    chk("stream_instr0", 64'(r_o_instr0), 64'h10);
    chk("stream_instr1", 64'(r_o_instr1), 64'h11);
    chk("stream_seq0", 64'(r_o_seq0), 64'd0);
    chk("stream_seq1", 64'(r_o_seq1), 64'd1);
    r_i_ready = 1'b1;
    wait_drain("stream", 60);
    r_i_ready = 1'b0;

    // Latency: re in N, capture at end of N+1, visible in N+2.
    push(32'hAB, 6'd8, 1);
    r_i_ready = 1'b1;
    #1;
    chk("lat_re_n", 64'(r_o_iq_re), 64'd1);
    chk("lat_valid_n", 64'(r_o_valid0), 64'd0);
    tick();
    chk("lat_valid_n1", 64'(r_o_valid0), 64'd0);
    tick();
    chk("lat_valid0_n2", 64'(r_o_valid0), 64'd1);
    chk("lat_valid1_n2", 64'(r_o_valid1), 64'd0);
    chk("lat_instr_n2", 64'(r_o_instr0), 64'hAB);
    tick();
    chk("lat_popped", 64'(r_o_count), 64'd0);
    r_i_ready = 1'b0;

    // Pop two while capturing one.
    push(32'h20, 6'd9, 1); push(32'h21, 6'd10, 1); push(32'h22, 6'd11, 1);
    repeat (8) tick();
    chk("odd_count3", 64'(r_o_count), 64'd3);
    push(32'h55, 6'd12, 1);
    tick();
    r_i_ready = 1'b1;
    tick();
    r_i_ready = 1'b0;
    chk("odd_count2", 64'(r_o_count), 64'd2);
    chk("odd_instr0", 64'(r_o_instr0), 64'h22);
    chk("odd_instr1", 64'(r_o_instr1), 64'h55);
    chk("odd_seq0", 64'(r_o_seq0), 64'd11);
    chk("odd_seq1", 64'(r_o_seq1), 64'd12);
    r_i_ready = 1'b1;
    wait_drain("odd", 30);
    r_i_ready = 1'b0;

    // Flush on the capture cycle of 0x77; the tag counter is kept.
    push(32'h77, 6'd0, 0);
    push(32'h78, 6'd13, 1);
    tick();
    r_i_flush = 1'b1;
    #1;
    chk("flush_re_low", 64'(r_o_iq_re), 64'd0);
    tick();
    r_i_flush = 1'b0;
    chk("flush_valid0", 64'(r_o_valid0), 64'd0);
    chk("flush_count", 64'(r_o_count), 64'd0);
    tick(); tick();
    chk("flush_next_valid", 64'(r_o_valid0), 64'd1);
    chk("flush_next_instr", 64'(r_o_instr0), 64'h78);
    chk("flush_next_seq", 64'(r_o_seq0), 64'd13);
    r_i_ready = 1'b1;
    wait_drain("flush", 30);
    r_i_ready = 1'b0;

    // Wrap: 70 words, ready toggling 1010, tags wrap past 63.
    r_rst = 1'b1;
    tick();
    r_rst = 1'b0;
    for (int i = 0; i < 70; i++) push(IW'(32'h100 + i), SW'(i % 64), 1);
    done = 0;
    for (int c = 0; c < 1000; c++) begin
      if (sb.size() == 0 && r_o_count == '0 && rd_idx == wr_idx) begin
        done = 1;
        break;
      end
      r_i_ready = (c % 2 == 0);
      tick();
    end
    r_i_ready = 1'b0;
    chk("wrap_drained", 64'(done), 64'd1);

    // Reset with three buffered and one in flight.
    for (int i = 0; i < 4; i++) push(IW'(32'h30 + i), 6'd0, 0);
    for (int c = 0; c < 20; c++) begin
      tick();
      if (r_o_count == CW'(3)) break;
    end
    chk("rst_mid_count3", 64'(r_o_count), 64'd3);
    r_rst = 1'b1;
    tick();
    r_rst = 1'b0;
    chk("rst_mid_valid0", 64'(r_o_valid0), 64'd0);
    chk("rst_mid_valid1", 64'(r_o_valid1), 64'd0);
    chk("rst_mid_count", 64'(r_o_count), 64'd0);
    repeat (3) tick();
    chk("rst_mid_ignored", 64'(r_o_count), 64'd0);
    push(32'h40, 6'd0, 1);
    r_i_ready = 1'b1;
    wait_drain("rst_mid", 30);
    r_i_ready = 1'b0;

    chk("max_count_le_depth", 64'(max_cnt <= 4), 64'd1);
    chk("scoreboard_empty", 64'(sb.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
